product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter SAT_EN, default 1, meaning: 1 = saturate the accumulator on signed overflow, 0 = wrap modulo 2^64.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  product beat present.
REQ-005 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-006 SHALL have port in_product  input  64  signed two's-complement product from the 32x32 Booth multiplier.
REQ-007 SHALL have port in_ovf  input  1  multiplier overflow flag for this beat.
REQ-008 SHALL have port in_last  input  1  final beat of the current group.
REQ-009 SHALL have port out_valid  output  1  group result available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_sum  output  64  signed accumulated group sum.
REQ-012 SHALL have port out_count  output  16  beats accepted in the group, including the last beat.
REQ-013 SHALL have port out_ovf  output  1  OR of in_ovf over all beats of the group.
REQ-014 SHALL have port out_sat  output  1  at least one accumulation in the group overflowed the signed 64-bit range.

Function
REQ-015 SHALL define a beat as accepted in any cycle with in_valid=1, in_ready=1 and rst=0.
REQ-016 SHALL drive in_ready = !out_valid && !rst, combinationally.
REQ-017 SHALL hold internal state acc (64), cnt (16), ovf_st and sat_st, all zero at the start of every group.
REQ-018 SHALL, on an accepted beat, compute s = acc + in_product as a signed 64-bit add; signed overflow is both operands sharing a sign that differs from the sign of s.
REQ-019 SHALL, on overflow, set sat_st; with SAT_EN=1, load acc with 0x7FFF_FFFF_FFFF_FFFF (positive operands) or 0x8000_0000_0000_0000 (negative operands); with SAT_EN=0, load acc with s.
REQ-020 SHALL, once sat_st is set, continue accumulating normally from the saturated value.
REQ-021 SHALL, on an accepted beat, increment cnt, saturating at 0xFFFF, and OR in_ovf into ovf_st.
REQ-022 SHALL operate as a two-state FSM: ACCUM (out_valid=0) and HOLD (out_valid=1).
REQ-023 SHALL, on an accepted beat with in_last=1 in ACCUM, register the post-update acc, cnt, ovf_st and sat_st into out_sum, out_count, out_ovf and out_sat, and enter HOLD, so that out_valid=1 in the next cycle (latency 1).
REQ-024 SHALL treat a group of one beat (in_last on the first beat) as out_sum = in_product and out_count = 1.
REQ-025 SHALL keep out_sum, out_count, out_ovf and out_sat stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, in HOLD with out_ready=1, clear acc, cnt, ovf_st and sat_st, deassert out_valid and return to ACCUM, so in_ready=1 in the following cycle.
REQ-027 SHALL sustain one accepted beat per cycle within a group, with a minimum of one non-accepting cycle (HOLD) between groups.
REQ-028 SHALL ignore in_product, in_ovf and in_last whenever the beat is not accepted.

Reset
REQ-029 SHALL, while rst=1, go to ACCUM and clear acc, cnt, ovf_st, sat_st, out_sum, out_count, out_ovf, out_sat and out_valid to 0; rst has priority over all handshakes.
REQ-030 SHALL discard a partially accumulated group, or a pending HOLD result, when rst is asserted mid-operation.
REQ-031 SHALL accept beats in the first cycle after rst is deasserted.

Verification
REQ-032 SHALL check reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0 and all outputs 0; after release in_ready=1.
REQ-033 SHALL check a basic group: beats 6, 0xFFFF_FFFF_FFFF_FFF1 (-15), 100 (last) on consecutive cycles -> next cycle out_valid=1, out_sum=91, out_count=3, out_ovf=0, out_sat=0.
REQ-034 SHALL check saturation: beats 0x7FFF_FFFF_FFFF_FFFF, 1 (last) -> SAT_EN=1: out_sum=0x7FFF_FFFF_FFFF_FFFF, out_sat=1; SAT_EN=0: out_sum=0x8000_0000_0000_0000, out_sat=1.
REQ-035 SHALL check overflow propagation: beats 2 (in_ovf=0), 3 (in_ovf=1, last) -> out_sum=5, out_count=2, out_ovf=1.
REQ-036 SHALL check backpressure: out_ready=0 for 5 cycles after a result with in_valid=1 held -> out_valid=1 and outputs unchanged, in_ready=0, no beat accepted; after the handshake, the next group of beat 7 (last) -> out_sum=7, out_count=1.
REQ-037 SHALL check reset mid-group: beats 10, 20, then rst for 1 cycle, then beat 5 (last) -> out_sum=5, out_count=1, out_ovf=0.

Source files
------------

// File: rtl/product_accumulator.sv
// Accumulates a group of signed 64-bit products, with optional saturation, and
// holds the group result under a valid/ready handshake until it is consumed.
module product_accumulator #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_product,
    input  logic        in_ovf,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum,
    output logic [15:0] out_count,
    output logic        out_ovf,
    output logic        out_sat
);

    localparam logic [63:0] SumMax = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SumMin = 64'h8000_0000_0000_0000;

    typedef enum logic {StAccum, StHold} state_e;

    state_e      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        sat_q, sat_d;

    logic        accept;
    logic [63:0] sum;
    logic        add_ovf;
    logic [63:0] acc_upd;
    logic [15:0] cnt_upd;
    logic        ovf_upd;
    logic        sat_upd;

    assign out_valid = (state_q == StHold);
    assign in_ready  = !out_valid && !rst;
    assign accept    = in_valid && in_ready;

    // Post-update values of the running state for the current beat.
    always_comb begin
        sum     = acc_q + in_product;
        add_ovf = (acc_q[63] == in_product[63]) && (sum[63] != acc_q[63]);
        acc_upd = sum;
        if (add_ovf && SAT_EN) begin
            acc_upd = acc_q[63] ? SumMin : SumMax;
        end
        cnt_upd = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        ovf_upd = ovf_q | in_ovf;
        sat_upd = sat_q | add_ovf;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sat_d   = sat_q;
        unique case (state_q)
            StAccum: begin
                if (accept) begin
                    acc_d = acc_upd;
                    cnt_d = cnt_upd;
                    ovf_d = ovf_upd;
                    sat_d = sat_upd;
                    if (in_last) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    sat_d   = 1'b0;
                    state_d = StAccum;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAccum;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sat_q   <= sat_d;
        end
    end

    // Result registers only load on the closing beat, so they stay put in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_sat   <= 1'b0;
        end else if (accept && in_last) begin
            out_sum   <= acc_upd;
            out_count <= cnt_upd;
            out_ovf   <= ovf_upd;
            out_sat   <= sat_upd;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: one instance per SAT_EN setting, fed
// identical stimulus, with a vector table plus hand-written corner sequences.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_product;
    logic        in_ovf;
    logic        in_last;
    logic        out_ready;

    logic        in_ready1, out_valid1, out_ovf1, out_sat1;
    logic [63:0] out_sum1;
    logic [15:0] out_count1;
    logic        in_ready0, out_valid0, out_ovf0, out_sat0;
    logic [63:0] out_sum0;
    logic [15:0] out_count0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    product_accumulator #(.SAT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_product(in_product), .in_ovf(in_ovf), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
        .out_count(out_count1), .out_ovf(out_ovf1), .out_sat(out_sat1)
    );

    product_accumulator #(.SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_product(in_product), .in_ovf(in_ovf), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
        .out_count(out_count0), .out_ovf(out_ovf0), .out_sat(out_sat0)
    );

    typedef struct {
        logic        v;
        logic [63:0] p;
        logic        o;
        logic        l;
        logic        ordy;
        logic        e_rdy;
        logic        e_val;
        logic [63:0] e_sum1;
        logic [63:0] e_sum0;
        logic [15:0] e_cnt;
        logic        e_ovf;
        logic        e_sat;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] p, input logic o, input logic l,
                         input logic ordy);
        in_valid   = v;
        in_product = p;
        in_ovf     = o;
        in_last    = l;
        out_ready  = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares a held result on both instances; sums differ only under saturation.
    task automatic chk_result(input string tag, input logic [63:0] s1, input logic [63:0] s0,
                              input logic [15:0] c, input logic ov, input logic st);
        chk({tag, " valid"},  {63'd0, out_valid1}, 64'd1);
        chk({tag, " valid0"}, {63'd0, out_valid0}, 64'd1);
        chk({tag, " sum"},    out_sum1, s1);
        chk({tag, " sum0"},   out_sum0, s0);
        chk({tag, " count"},  {48'd0, out_count1}, {48'd0, c});
        chk({tag, " count0"}, {48'd0, out_count0}, {48'd0, c});
        chk({tag, " ovf"},    {63'd0, out_ovf1}, {63'd0, ov});
        chk({tag, " sat"},    {63'd0, out_sat1}, {63'd0, st});
        chk({tag, " sat0"},   {63'd0, out_sat0}, {63'd0, st});
    endtask

    initial begin
        // Each row: inputs for this cycle, and outputs expected before its clock edge.
        tbl[0]  = '{1, 64'd6,                  0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 64'd100,                0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 64'd0,                  0, 0, 1, 0, 1, 64'd91, 64'd91, 16'd3, 0, 0};
        tbl[4]  = '{1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 64'd1,                  0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 64'd0,                  0, 0, 1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000, 16'd2, 0, 1};
        tbl[7]  = '{1, 64'd2,                  0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 64'd3,                  1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 64'd0,                  0, 0, 1, 0, 1, 64'd5, 64'd5, 16'd2, 1, 0};
        tbl[10] = '{1, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 64'd0,                  0, 0, 1, 0, 1, 64'h8000_0000_0000_0000,
                    64'h7FFF_FFFF_FFFF_FFFF, 16'd2, 0, 1};
        // Saturate, then keep accumulating from the clamped value.
        tbl[13] = '{1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{1, 64'd1,                  0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{1, 64'hFFFF_FFFF_FFFF_FFFB, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{0, 64'd0,                  0, 0, 1, 0, 1, 64'h7FFF_FFFF_FFFF_FFFA,
                    64'h7FFF_FFFF_FFFF_FFFB, 16'd3, 0, 1};

        // Reset with a beat offered: nothing accepted, everything cleared.
        rst = 1'b1;
        drive(1, 64'd55, 1, 1, 0);
        tick();
        tick();
        chk("rst in_ready", {63'd0, in_ready1}, 64'd0);
        chk("rst out_valid", {63'd0, out_valid1}, 64'd0);
        chk("rst out_sum", out_sum1, 64'd0);
        chk("rst out_count", {48'd0, out_count1}, 64'd0);
        chk("rst out_ovf", {63'd0, out_ovf1}, 64'd0);
        chk("rst out_sat", {63'd0, out_sat1}, 64'd0);
        drive(0, 64'd0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", {63'd0, in_ready1}, 64'd1);
        @(negedge clk);
        tick();

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].p, tbl[i].o, tbl[i].l, tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d in_ready", i), {63'd0, in_ready1}, {63'd0, tbl[i].e_rdy});
            chk($sformatf("vec%0d out_valid", i), {63'd0, out_valid1}, {63'd0, tbl[i].e_val});
            if (tbl[i].e_val) begin
                chk_result($sformatf("vec%0d", i), tbl[i].e_sum1, tbl[i].e_sum0,
                           tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_sat);
            end
            tick();
        end

        // Backpressure: result held for 5 cycles while a beat is offered.
        drive(1, 64'd11, 0, 1, 0);
        tick();
        drive(1, 64'd999, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp%0d in_ready", i), {63'd0, in_ready1}, 64'd0);
            chk_result($sformatf("bp%0d", i), 64'd11, 64'd11, 16'd1, 0, 0);
            tick();
        end
        drive(1, 64'd999, 1, 1, 1);
        tick();
        drive(1, 64'd7, 0, 1, 0);
        #1;
        chk("bp next in_ready", {63'd0, in_ready1}, 64'd1);
        tick();
        drive(0, 64'd0, 0, 0, 0);
        #1;
        chk_result("bp next", 64'd7, 64'd7, 16'd1, 0, 0);
        out_ready = 1'b1;
        tick();

        // Reset in the middle of a group discards it; first beat after is accepted.
        drive(1, 64'd10, 1, 0, 0);
        tick();
        drive(1, 64'd20, 0, 0, 0);
        tick();
        rst = 1'b1;
        drive(1, 64'd1000, 1, 1, 0);
        #1;
        chk("midrst in_ready", {63'd0, in_ready1}, 64'd0);
        tick();
        rst = 1'b0;
        drive(1, 64'd5, 0, 1, 0);
        #1;
        chk("midrst resume in_ready", {63'd0, in_ready1}, 64'd1);
        tick();
        drive(0, 64'd0, 0, 0, 0);
        #1;
        chk_result("midrst", 64'd5, 64'd5, 16'd1, 0, 0);

        // Reset also drops a pending result.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("holdrst out_valid", {63'd0, out_valid1}, 64'd0);
        chk("holdrst out_sum", out_sum1, 64'd0);
        chk("holdrst in_ready", {63'd0, in_ready1}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
